// File: rtl/bridge_req_queue.sv
// Command queue between an upstream register-style master and a downstream
// target. Commands are buffered in a small FIFO and issued one at a time,
// honouring target back-pressure, a minimum inter-command gap and a
// fixed-latency read return path.
module bridge_req_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2,
  parameter int GAP        = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_WIDTH-1:0]    in_addr,
  input  logic [DATA_WIDTH-1:0]    in_wr_data,
  input  logic                     in_wr,
  input  logic                     in_rd,
  output logic [DATA_WIDTH-1:0]    in_rd_data,
  output logic                     rd_done,
  output logic [ADDR_WIDTH-1:0]    out_addr,
  output logic [DATA_WIDTH-1:0]    out_wr_data,
  output logic                     out_wr,
  output logic                     out_rd,
  input  logic [DATA_WIDTH-1:0]    out_rd_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  // Queue storage; only entries between the pointers are ever read.
  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic                  mem_wr   [DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [3:0]            gap_q, gap_d;
  logic [3:0]            rd_cnt_q, rd_cnt_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  overflow_q, overflow_d;
  logic                  rd_done_q, rd_done_d;
  logic                  out_wr_q, out_wr_d;
  logic                  out_rd_q, out_rd_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0] out_wr_data_q, out_wr_data_d;
  logic [DATA_WIDTH-1:0] in_rd_data_q, in_rd_data_d;

  logic cmd_req, full_int, push, drop, rd_last, issue, head_wr;

  // Queue bookkeeping, issue decision and read-return tracking.
  always_comb begin
    cmd_req  = in_wr | in_rd;
    full_int = (level_q == LW'(DEPTH));
    push     = cmd_req & ~full_int;
    drop     = cmd_req & full_int;
    // The read completes this cycle, so the next command may already issue.
    rd_last  = rd_pend_q & (rd_cnt_q == 4'd0);
    issue    = (level_q != '0) & out_ready & (gap_q == 4'd0) & (~rd_pend_q | rd_last);
    head_wr  = mem_wr[rd_ptr_q];

    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    gap_d         = gap_q;
    rd_cnt_d      = rd_cnt_q;
    rd_pend_d     = rd_pend_q;
    out_wr_d      = 1'b0;
    out_rd_d      = 1'b0;
    out_addr_d    = out_addr_q;
    out_wr_data_d = out_wr_data_q;
    in_rd_data_d  = in_rd_data_q;
    rd_done_d     = rd_last;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);

    if (issue) begin
      rd_ptr_d      = rd_ptr_q + PW'(1);
      out_addr_d    = mem_addr[rd_ptr_q];
      out_wr_data_d = mem_data[rd_ptr_q];
      out_wr_d      = head_wr;
      out_rd_d      = ~head_wr;
      gap_d         = 4'(GAP);
    end else if (gap_q != 4'd0) begin
      gap_d = gap_q - 4'd1;
    end

    case ({push, issue})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (rd_last) in_rd_data_d = out_rd_data;

    if (issue && !head_wr) begin
      rd_pend_d = 1'b1;
      rd_cnt_d  = 4'(RD_LATENCY);
    end else if (rd_last) begin
      rd_pend_d = 1'b0;
    end else if (rd_pend_q) begin
      rd_cnt_d = rd_cnt_q - 4'd1;
    end

    // A drop in the same cycle as a clear keeps the flag set.
    if (drop)              overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
    else                   overflow_d = overflow_q;
  end

  // Entry write on accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr_q] <= in_addr;
      mem_data[wr_ptr_q] <= in_wr_data;
      mem_wr[wr_ptr_q]   <= in_wr;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      gap_q         <= '0;
      rd_cnt_q      <= '0;
      rd_pend_q     <= 1'b0;
      overflow_q    <= 1'b0;
      rd_done_q     <= 1'b0;
      out_wr_q      <= 1'b0;
      out_rd_q      <= 1'b0;
      out_addr_q    <= '0;
      out_wr_data_q <= '0;
      in_rd_data_q  <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      gap_q         <= gap_d;
      rd_cnt_q      <= rd_cnt_d;
      rd_pend_q     <= rd_pend_d;
      overflow_q    <= overflow_d;
      rd_done_q     <= rd_done_d;
      out_wr_q      <= out_wr_d;
      out_rd_q      <= out_rd_d;
      out_addr_q    <= out_addr_d;
      out_wr_data_q <= out_wr_data_d;
      in_rd_data_q  <= in_rd_data_d;
    end
  end

  assign level       = level_q;
  assign full        = full_int;
  assign overflow    = overflow_q;
  assign rd_done     = rd_done_q;
  assign out_wr      = out_wr_q;
  assign out_rd      = out_rd_q;
  assign out_addr    = out_addr_q;
  assign out_wr_data = out_wr_data_q;
  assign in_rd_data  = in_rd_data_q;

endmodule

// File: tb/tb_bridge_req_queue.sv
// Bench for bridge_req_queue: scoreboard of expected commands and read
// returns, a downstream target model, directed scenarios and a random run.
module tb_bridge_req_queue;
  localparam int DEPTH = 4;
  localparam int RL    = 2;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic [31:0] in_addr = '0, in_wr_data = '0, out_rd_data = '0;
  logic        in_wr = 1'b0, in_rd = 1'b0, out_ready = 1'b0, overflow_clr = 1'b0;
  logic [31:0] in_rd_data, out_addr, out_wr_data;
  logic        rd_done, out_wr, out_rd, full, overflow;
  logic [2:0]  level;
  logic [31:0] g_in_rd_data, g_out_addr, g_out_wr_data;
  logic        g_rd_done, g_out_wr, g_out_rd, g_full, g_overflow;
  logic [2:0]  g_level;

  bridge_req_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(RL), .GAP(0)) dut (
    .clk(clk), .reset_n(reset_n), .in_addr(in_addr), .in_wr_data(in_wr_data),
    .in_wr(in_wr), .in_rd(in_rd), .in_rd_data(in_rd_data), .rd_done(rd_done),
    .out_addr(out_addr), .out_wr_data(out_wr_data), .out_wr(out_wr), .out_rd(out_rd),
    .out_rd_data(out_rd_data), .out_ready(out_ready), .level(level), .full(full),
    .overflow(overflow), .overflow_clr(overflow_clr));

  bridge_req_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(RL), .GAP(3)) dut_gap (
    .clk(clk), .reset_n(reset_n), .in_addr(in_addr), .in_wr_data(in_wr_data),
    .in_wr(in_wr), .in_rd(in_rd), .in_rd_data(g_in_rd_data), .rd_done(g_rd_done),
    .out_addr(g_out_addr), .out_wr_data(g_out_wr_data), .out_wr(g_out_wr), .out_rd(g_out_rd),
    .out_rd_data(out_rd_data), .out_ready(out_ready), .level(g_level), .full(g_full),
    .overflow(g_overflow), .overflow_clr(overflow_clr));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; } cmd_t;
  typedef struct { logic [31:0] val; int due; } rd_t;
  cmd_t exp_q[$];
  rd_t  rd_exp[$];
  rd_t  tgt_q[$];
  int   wr_log[$], rd_log[$], gap_log[$];
  bit   model_ovf = 1'b0;
  bit   fixed_rd = 1'b0;
  int   last_rd_cyc = -100;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor plus downstream target: checks every strobe and read return.
  initial forever begin
    @(posedge clk); #1;
    if (reset_n) begin
      bit   exp_done;
      cmd_t e;
      exp_done = (rd_exp.size() > 0) && (rd_exp[0].due == cyc);
      check("rd_done", rd_done, exp_done);
      if (exp_done) begin
        check("in_rd_data", in_rd_data, rd_exp[0].val);
        void'(rd_exp.pop_front());
      end
      check("dual_strobe", out_wr & out_rd, 0);
      if (out_wr | out_rd) begin
        check("strobe_ready", out_ready, 1);
        check("rd_spacing", cyc >= last_rd_cyc + RL + 1, 1);
        check("strobe_has_entry", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("strobe_kind", out_wr, e.wr);
          check("out_addr", out_addr, e.addr);
          check("out_wr_data", out_wr_data, e.data);
        end
        if (out_wr) wr_log.push_back(cyc);
        if (out_rd) begin
          rd_log.push_back(cyc);
          last_rd_cyc = cyc;
          tgt_q.push_back('{val: '0, due: cyc + RL});
        end
      end
      if (tgt_q.size() > 0 && tgt_q[0].due == cyc) begin
        logic [31:0] v;
        v = fixed_rd ? 32'hCAFEF00D : $urandom;
        out_rd_data = v;
        rd_exp.push_back('{val: v, due: cyc + 1});
        void'(tgt_q.pop_front());
      end else begin
        out_rd_data = $urandom;
      end
      if (g_out_wr) gap_log.push_back(cyc);
    end
  end

  // One stimulus cycle: check queue status against the model, then drive.
  task automatic step(bit w, bit r, logic [31:0] a, logic [31:0] d, bit clr, bit rdy);
    bit drop;
    @(posedge clk); #2;
    check("level", level, exp_q.size());
    check("full", full, exp_q.size() == DEPTH);
    check("overflow", overflow, model_ovf);
    in_wr = w; in_rd = r; in_addr = a; in_wr_data = d;
    overflow_clr = clr; out_ready = rdy;
    drop = 1'b0;
    if (w | r) begin
      if (exp_q.size() < DEPTH) exp_q.push_back('{wr: w, addr: a, data: d});
      else drop = 1'b1;
    end
    model_ovf = drop ? 1'b1 : (clr ? 1'b0 : model_ovf);
  endtask

  task automatic idle(bit rdy);
    step(0, 0, '0, '0, 0, rdy);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset_n = 1'b0;
    in_wr = 0; in_rd = 0; overflow_clr = 0; out_ready = 0;
    exp_q.delete(); rd_exp.delete(); tgt_q.delete();
    wr_log.delete(); rd_log.delete(); gap_log.delete();
    model_ovf = 1'b0; last_rd_cyc = -100;
    #1;
    check("rst_level", level, 0);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_out_wr", out_wr, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_wr_data", out_wr_data, 0);
    check("rst_in_rd_data", in_rd_data, 0);
    check("rst_rd_done", rd_done, 0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    // Back-to-back writes, two-cycle push-to-strobe latency.
    do_reset();
    step(1, 0, 32'h10, 32'hA0, 0, 1); p = cyc;
    step(1, 0, 32'h14, 32'hA4, 0, 1);
    step(1, 0, 32'h18, 32'hA8, 0, 1);
    repeat (5) idle(1);
    check("d1_count", wr_log.size(), 3);
    for (int i = 0; i < 3; i++)
      check("d1_time", (i < wr_log.size()) ? wr_log[i] : -1, p + 2 + i);

    // Read with fixed latency, then a queued write held off by the pending read.
    do_reset();
    fixed_rd = 1'b1;
    step(0, 1, 32'h20, 32'h0, 0, 1); p = cyc;
    step(1, 0, 32'h30, 32'h55, 0, 1);
    repeat (8) idle(1);
    fixed_rd = 1'b0;
    check("d2_rd_count", rd_log.size(), 1);
    check("d2_wr_count", wr_log.size(), 1);
    if (rd_log.size() == 1 && wr_log.size() == 1) begin
      check("d2_rd_time", rd_log[0], p + 2);
      check("d2_wr_after_rd", wr_log[0] - rd_log[0], 3);
    end
    check("d2_rd_data", in_rd_data, 32'hCAFEF00D);

    // Fill while stalled, overflow, clear, then drain in order.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 32'h40 + 4 * i, 32'h100 + i, 0, 0);
    idle(0);
    check("d3_level", level, 4);
    check("d3_full", full, 1);
    check("d3_overflow", overflow, 1);
    step(0, 0, '0, '0, 1, 0);
    idle(0);
    check("d3_overflow_clr", overflow, 0);
    repeat (8) idle(1);
    check("d3_drained", wr_log.size(), 4);

    // Minimum gap between issues on the GAP=3 instance.
    do_reset();
    step(1, 0, 32'h50, 32'h5, 0, 1);
    step(1, 0, 32'h54, 32'h6, 0, 1);
    repeat (12) idle(1);
    check("d4_count", gap_log.size(), 2);
    if (gap_log.size() == 2) check("d4_spacing", gap_log[1] - gap_log[0], 4);

    // Simultaneous write and read strobes become one write.
    do_reset();
    step(1, 1, 32'h60, 32'h66, 0, 1);
    idle(1);
    repeat (4) idle(1);
    check("d5_wr", wr_log.size(), 1);
    check("d5_rd", rd_log.size(), 0);

    // Reset one cycle after out_rd discards the read.
    do_reset();
    step(0, 1, 32'h70, 32'h0, 0, 1);
    idle(1);
    idle(1);
    check("d6_rd_seen", rd_log.size(), 1);
    do_reset();
    repeat (6) idle(1);
    check("d6_in_rd_data", in_rd_data, 0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 25, $urandom, $urandom,
           $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 75);
    repeat (40) idle(1);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_reads_done", rd_exp.size() + tgt_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
